mux_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit datapath port between two requesters.
- Drives the select line of the downstream 2:1 byte mux: sel=0 picks requester 1, sel=1 picks requester 2.
- Captures the granted byte into a single output register with a valid/ready handshake toward the consumer.
- Sits between CPU-side byte producers (e.g. store-byte path and debug/loader path) and a single-ported byte consumer.

---
 rtl/mux_share_arbiter.sv | 131 +++++++++++++
 tb/tb_mux_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter that shares one byte port between two requesters.
// It drives the downstream mux select and holds one output register with a valid/ready handshake.
module mux_share_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              req2,
  input  logic [DATA_W-1:0] data2,
  output logic              ack2,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);

  typedef enum logic [1:0] {StIdle, StG1, StG2} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  // Set when requester 2 held the most recent grant.
  logic                last2_q, last2_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic            can_load;
  logic            accept;
  logic [CntW-1:0] cnt_inc;
  logic            go1, go2;

  assign can_load = !out_valid_q || out_ready;
  assign ack1     = (state_q == StG1) && req1 && can_load;
  assign ack2     = (state_q == StG2) && req2 && can_load;
  assign accept   = ack1 || ack2;
  assign cnt_inc  = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last2_d = last2_q;
    cnt_d   = cnt_q;
    go1     = 1'b0;
    go2     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req1 && (!req2 || last2_q)) begin
          go1 = 1'b1;
        end else if (req2) begin
          go2 = 1'b1;
        end
      end
      StG1: begin
        if (!req1) begin
          if (req2) go2 = 1'b1;
          else      state_d = StIdle;
        end else if (req2 && (ack1 ? (cnt_inc == MaxCnt) : (cnt_q == MaxCnt))) begin
          go2 = 1'b1;
        end
      end
      StG2: begin
        if (!req2) begin
          if (req1) go1 = 1'b1;
          else      state_d = StIdle;
        end else if (req1 && (ack2 ? (cnt_inc == MaxCnt) : (cnt_q == MaxCnt))) begin
          go1 = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) cnt_d = cnt_inc;

    // Grant entry overrides the beat count update of the final beat.
    if (go1) begin
      state_d = StG1;
      sel_d   = 1'b0;
      last2_d = 1'b0;
      cnt_d   = '0;
    end else if (go2) begin
      state_d = StG2;
      sel_d   = 1'b1;
      last2_d = 1'b1;
      cnt_d   = '0;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = ack2 ? data2 : data1;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      last2_q     <= 1'b1;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last2_q     <= last2_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: reset, fairness, release, streaming, stall, mid-burst reset.
module tb_mux_share_arbiter;

  logic       clk;
  logic       rst;
  logic       req1, req2;
  logic [7:0] data1, data2;
  logic       ack1, ack2;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mux_share_arbiter #(
    .DATA_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req1     (req1),
    .data1    (data1),
    .ack1     (ack1),
    .req2     (req2),
    .data2    (data2),
    .ack2     (ack2),
    .sel      (sel),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven at +1 and outputs sampled at +3.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Grant owner per beat with both requesters busy: 4 to req1, 4 to req2, 4 to req1.
  localparam logic [11:0] G2Pat = 12'b0000_1111_0000;

  logic [7:0] exp_prev;

  initial begin
    rst       = 1'b1;
    req1      = 1'b1;
    req2      = 1'b1;
    data1     = 8'h10;
    data2     = 8'h80;
    out_ready = 1'b1;
    step();
    step();
    settle();
    check_eq("rst_ack1", ack1, 0);
    check_eq("rst_ack2", ack2, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_busy", busy, 0);

    rst = 1'b0;
    settle();
    check_eq("arb_ack1", ack1, 0);
    check_eq("arb_busy", busy, 0);
    step();

    // Fairness with both requests held; data changes every cycle.
    exp_prev = 8'h00;
    for (int k = 0; k < 12; k++) begin
      data1 = 8'h10 + 8'(k);
      data2 = 8'h80 + 8'(k);
      settle();
      check_eq($sformatf("fair_ack1_%0d", k), ack1, {31'd0, !G2Pat[k]});
      check_eq($sformatf("fair_ack2_%0d", k), ack2, {31'd0, G2Pat[k]});
      check_eq($sformatf("fair_sel_%0d", k), sel, {31'd0, G2Pat[k]});
      check_eq($sformatf("fair_busy_%0d", k), busy, 1);
      if (k > 0) begin
        check_eq($sformatf("fair_data_%0d", k), out_data, exp_prev);
        check_eq($sformatf("fair_valid_%0d", k), out_valid, 1);
      end
      exp_prev = G2Pat[k] ? data2 : data1;
      step();
    end

    // Now in G2 with no beats; one beat, then req2 drops.
    data2 = 8'hC1;
    settle();
    check_eq("rel_ack2", ack2, 1);
    check_eq("rel_sel2", sel, 1);
    step();
    req2 = 1'b0;
    settle();
    check_eq("rel_noack1", ack1, 0);
    check_eq("rel_noack2", ack2, 0);
    check_eq("rel_data", out_data, 8'hC1);
    step();

    // Sole requester streams past MAX_HOLD.
    for (int k = 0; k < 5; k++) begin
      data1 = 8'h11 * 8'(k + 1);
      settle();
      check_eq($sformatf("str_ack1_%0d", k), ack1, 1);
      check_eq($sformatf("str_sel_%0d", k), sel, 0);
      if (k > 0) check_eq($sformatf("str_data_%0d", k), out_data, 8'h11 * 8'(k));
      step();
    end
    check_eq("str_data_last", out_data, 8'h55);

    // Backpressure: three stalled cycles, then accept in the ready cycle.
    data1     = 8'h66;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq($sformatf("bp_ack1_%0d", k), ack1, 0);
      check_eq($sformatf("bp_data_%0d", k), out_data, 8'h55);
      check_eq($sformatf("bp_valid_%0d", k), out_valid, 1);
      check_eq($sformatf("bp_busy_%0d", k), busy, 1);
      step();
    end
    out_ready = 1'b1;
    settle();
    check_eq("bp_resume_ack1", ack1, 1);
    step();
    check_eq("bp_resume_data", out_data, 8'h66);

    // Saturated count with req2 waiting and no accept switches to G2.
    data1     = 8'h77;
    req2      = 1'b1;
    data2     = 8'hD1;
    out_ready = 1'b0;
    settle();
    check_eq("sat_ack1", ack1, 0);
    check_eq("sat_ack2", ack2, 0);
    step();
    settle();
    check_eq("sat_sel", sel, 1);
    check_eq("sat_stall_ack2", ack2, 0);
    out_ready = 1'b1;
    #1;
    check_eq("sat_ack2", ack2, 1);
    step();
    check_eq("sat_data", out_data, 8'hD1);

    // Reset mid-burst with a held byte.
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    settle();
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_sel", sel, 0);
    check_eq("mrst_data", out_data, 0);
    check_eq("mrst_ack2", ack2, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    data1 = 8'hE1;
    settle();
    check_eq("mrst_tie_ack1", ack1, 1);
    check_eq("mrst_tie_ack2", ack2, 0);
    check_eq("mrst_tie_sel", sel, 0);
    step();

    // Both drop: G1 releases to IDLE and the held byte drains.
    req1 = 1'b0;
    req2 = 1'b0;
    settle();
    check_eq("drain_data", out_data, 8'hE1);
    check_eq("drain_valid", out_valid, 1);
    step();
    settle();
    check_eq("drain_valid_low", out_valid, 0);
    check_eq("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (ack1 && ack2) begin
      errors++;
      $display("FAIL ack_overlap: got ack1=1 ack2=1 expected at most one");
    end
  end

endmodule
